// File: rtl/uart_fifo.sv
// Memory-mapped UART with TX/RX FIFOs, optional parity, 1/2 stop bits,
// sticky W1C error flags and a registered level interrupt.
module uart_fifo #(
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned DEFAULT_BAUD = 433
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic        re,
    input  logic [2:0]  reg_num,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    input  logic        rx,
    output logic        tx,
    output logic        irq
);
    localparam int unsigned AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] LVL_FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [3:0]  LAST_BIT = 4'(DATA_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    logic [7:0]  r_ctrl;
    logic [15:0] r_baud;
    logic        r_rx_ovr, r_frm_err, r_par_err, r_tx_ovf, r_irq;

    logic [DATA_BITS-1:0] r_tx_mem [FIFO_DEPTH];
    logic [DATA_BITS-1:0] r_rx_mem [FIFO_DEPTH];
    logic [AW-1:0] r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;
    logic [AW:0]   r_tx_lvl, r_rx_lvl;

    state_t               r_tx_state, r_rx_state;
    logic                 r_tx, r_tx_par, r_tx_pen, r_tx_stop2, r_tx_stop_more;
    logic [15:0]          r_tx_cnt, r_tx_baud, r_rx_cnt, r_rx_baud, r_rx_half;
    logic [3:0]           r_tx_bit, r_rx_bit;
    logic [DATA_BITS-1:0] r_tx_shift, r_rx_shift;
    logic                 r_rx_s1, r_rx_s2, r_rx_prev, r_rx_pen, r_rx_podd;

    logic        w_rd_en, w_wr_stat, w_wr_tdr;
    logic        w_tx_full, w_tx_busy, w_tx_tick, w_tx_pop, w_tx_push, w_tx_ovf_set;
    logic        w_rx_full, w_rx_tick, w_rx_fall, w_rx_done, w_rx_pop, w_rx_push;
    logic        w_rx_ovr_set, w_par_set, w_frm_set;
    logic [15:0] w_baud_eff;
    logic [DATA_BITS-1:0] w_tx_head, w_rx_head;
    logic [31:0] w_stat, w_rd_val;
    logic        w_unused;

    assign w_unused     = ^wd[31:16];
    assign w_rd_en      = re && !we;
    assign w_wr_stat    = we && (reg_num == 3'd1);
    assign w_wr_tdr     = we && (reg_num == 3'd3);
    assign w_baud_eff   = (r_baud < 16'd3) ? 16'd3 : r_baud;

    assign w_tx_head    = r_tx_mem[r_tx_rp];
    assign w_tx_full    = (r_tx_lvl == LVL_FULL);
    assign w_tx_busy    = (r_tx_state != S_IDLE);
    assign w_tx_tick    = (r_tx_cnt == r_tx_baud);
    // A pop either starts a frame from IDLE or chains straight out of the last stop bit.
    assign w_tx_pop     = r_ctrl[0] && (r_tx_lvl != '0) &&
                          ((r_tx_state == S_IDLE) ||
                           ((r_tx_state == S_STOP) && w_tx_tick && !r_tx_stop_more));
    assign w_tx_push    = w_wr_tdr && (!w_tx_full || w_tx_pop);
    assign w_tx_ovf_set = w_wr_tdr && w_tx_full && !w_tx_pop;

    assign w_rx_head    = r_rx_mem[r_rx_rp];
    assign w_rx_full    = (r_rx_lvl == LVL_FULL);
    assign w_rx_tick    = (r_rx_cnt == r_rx_baud);
    assign w_rx_fall    = r_rx_prev && !r_rx_s2;
    assign w_rx_done    = (r_rx_state == S_STOP) && w_rx_tick;
    assign w_rx_pop     = w_rd_en && (reg_num == 3'd4) && (r_rx_lvl != '0);
    assign w_rx_push    = w_rx_done && (!w_rx_full || w_rx_pop);
    assign w_rx_ovr_set = w_rx_done && w_rx_full && !w_rx_pop;
    assign w_par_set    = (r_rx_state == S_PARITY) && w_rx_tick &&
                          (r_rx_s2 != ((^r_rx_shift) ^ r_rx_podd));
    assign w_frm_set    = w_rx_done && !r_rx_s2;

    assign tx  = r_tx;
    assign irq = r_irq;

    always_comb begin
        w_stat        = '0;
        w_stat[0]     = w_tx_full;
        w_stat[1]     = w_tx_busy;
        w_stat[2]     = (r_tx_lvl == '0);
        w_stat[3]     = (r_rx_lvl != '0);
        w_stat[4]     = w_rx_full;
        w_stat[5]     = r_rx_ovr;
        w_stat[6]     = r_frm_err;
        w_stat[7]     = r_par_err;
        w_stat[8]     = r_tx_ovf;
        w_stat[23:16] = 8'(r_rx_lvl);
        w_stat[31:24] = 8'(r_tx_lvl);
    end

    always_comb begin
        w_rd_val = '0;
        case (reg_num)
            3'd0:    w_rd_val = {24'd0, r_ctrl};
            3'd1:    w_rd_val = w_stat;
            3'd2:    w_rd_val = {16'd0, r_baud};
            3'd4:    w_rd_val = (r_rx_lvl != '0) ? 32'(w_rx_head) : '0;
            default: w_rd_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wp] <= wd[DATA_BITS-1:0];
        if (w_rx_push) r_rx_mem[r_rx_wp] <= r_rx_shift;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctrl    <= '0;
            r_baud    <= 16'(DEFAULT_BAUD);
            rd        <= '0;
            r_irq     <= 1'b0;
            r_rx_ovr  <= 1'b0;
            r_frm_err <= 1'b0;
            r_par_err <= 1'b0;
            r_tx_ovf  <= 1'b0;
            r_tx_wp   <= '0;
            r_tx_rp   <= '0;
            r_tx_lvl  <= '0;
            r_rx_wp   <= '0;
            r_rx_rp   <= '0;
            r_rx_lvl  <= '0;
        end else begin
            if (we && reg_num == 3'd0) r_ctrl <= wd[7:0];
            if (we && reg_num == 3'd2) r_baud <= wd[15:0];
            if (w_rd_en) rd <= w_rd_val;
            // Sticky flags: a set in the same cycle as a W1C clear wins.
            r_rx_ovr  <= w_rx_ovr_set | (r_rx_ovr  & ~(w_wr_stat & wd[5]));
            r_frm_err <= w_frm_set    | (r_frm_err & ~(w_wr_stat & wd[6]));
            r_par_err <= w_par_set    | (r_par_err & ~(w_wr_stat & wd[7]));
            r_tx_ovf  <= w_tx_ovf_set | (r_tx_ovf  & ~(w_wr_stat & wd[8]));
            r_irq     <= (r_ctrl[5] & w_stat[3]) | (r_ctrl[6] & w_stat[2] & ~w_tx_busy) |
                         (r_ctrl[7] & (|w_stat[8:5]));
            if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
            if (w_tx_pop)  r_tx_rp <= r_tx_rp + 1'b1;
            if (w_tx_push && !w_tx_pop) r_tx_lvl <= r_tx_lvl + 1'b1;
            else if (!w_tx_push && w_tx_pop) r_tx_lvl <= r_tx_lvl - 1'b1;
            if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
            if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
            if (w_rx_push && !w_rx_pop) r_rx_lvl <= r_rx_lvl + 1'b1;
            else if (!w_rx_push && w_rx_pop) r_rx_lvl <= r_rx_lvl - 1'b1;
        end
    end

    // Frame format and bit period are latched when a frame starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_state     <= S_IDLE;
            r_tx           <= 1'b1;
            r_tx_cnt       <= '0;
            r_tx_baud      <= '0;
            r_tx_bit       <= '0;
            r_tx_shift     <= '0;
            r_tx_par       <= 1'b0;
            r_tx_pen       <= 1'b0;
            r_tx_stop2     <= 1'b0;
            r_tx_stop_more <= 1'b0;
        end else if (w_tx_pop) begin
            r_tx_state <= S_START;
            r_tx       <= 1'b0;
            r_tx_cnt   <= '0;
            r_tx_baud  <= w_baud_eff;
            r_tx_shift <= w_tx_head;
            r_tx_par   <= (^w_tx_head) ^ r_ctrl[3];
            r_tx_pen   <= r_ctrl[2];
            r_tx_stop2 <= r_ctrl[4];
        end else if (r_tx_state != S_IDLE) begin
            if (!w_tx_tick) begin
                r_tx_cnt <= r_tx_cnt + 1'b1;
            end else begin
                r_tx_cnt <= '0;
                case (r_tx_state)
                    S_START: begin
                        r_tx_state <= S_DATA;
                        r_tx       <= r_tx_shift[0];
                        r_tx_bit   <= '0;
                    end
                    S_DATA: begin
                        if (r_tx_bit == LAST_BIT) begin
                            r_tx_state     <= r_tx_pen ? S_PARITY : S_STOP;
                            r_tx           <= r_tx_pen ? r_tx_par : 1'b1;
                            r_tx_stop_more <= r_tx_stop2;
                        end else begin
                            r_tx_shift <= r_tx_shift >> 1;
                            r_tx       <= r_tx_shift[1];
                            r_tx_bit   <= r_tx_bit + 1'b1;
                        end
                    end
                    S_PARITY: begin
                        r_tx_state     <= S_STOP;
                        r_tx           <= 1'b1;
                        r_tx_stop_more <= r_tx_stop2;
                    end
                    S_STOP: begin
                        if (r_tx_stop_more) r_tx_stop_more <= 1'b0;
                        else                r_tx_state     <= S_IDLE;
                        r_tx <= 1'b1;
                    end
                    default: begin
                        r_tx_state <= S_IDLE;
                        r_tx       <= 1'b1;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_state <= S_IDLE;
            r_rx_cnt   <= '0;
            r_rx_baud  <= '0;
            r_rx_half  <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_pen   <= 1'b0;
            r_rx_podd  <= 1'b0;
        end else begin
            r_rx_s1   <= rx;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= r_rx_s2;
            case (r_rx_state)
                S_IDLE: begin
                    if (r_ctrl[1] && w_rx_fall) begin
                        r_rx_state <= S_START;
                        r_rx_cnt   <= '0;
                        r_rx_baud  <= w_baud_eff;
                        r_rx_half  <= 16'(({1'b0, w_baud_eff} + 17'd1) >> 1);
                        r_rx_pen   <= r_ctrl[2];
                        r_rx_podd  <= r_ctrl[3];
                    end
                end
                S_START: begin
                    if (r_rx_cnt == r_rx_half) begin
                        r_rx_state <= r_rx_s2 ? S_IDLE : S_DATA;
                        r_rx_cnt   <= '0;
                        r_rx_bit   <= '0;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_rx_tick) begin
                        r_rx_cnt   <= '0;
                        r_rx_shift <= {r_rx_s2, r_rx_shift[DATA_BITS-1:1]};
                        if (r_rx_bit == LAST_BIT) r_rx_state <= r_rx_pen ? S_PARITY : S_STOP;
                        else                      r_rx_bit   <= r_rx_bit + 1'b1;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (w_rx_tick) begin
                        r_rx_cnt   <= '0;
                        r_rx_state <= S_STOP;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_rx_tick) r_rx_state <= S_IDLE;
                    else           r_rx_cnt   <= r_rx_cnt + 1'b1;
                end
                default: r_rx_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_fifo.sv
// Directed bench for uart_fifo: TX framing, parity/stop options, loopback,
// RX overflow, framing error, glitch rejection, interrupts and reset.
module tb_uart_fifo;
    localparam int unsigned DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [2:0]  reg_num = '0;
    logic [31:0] wd = '0;
    logic [31:0] rd;
    logic        rx;
    logic        tx;
    logic        irq;
    logic        rx_drv = 1'b1;
    logic        loop = 1'b0;
    logic [31:0] v;
    int          errors = 0;
    int          checks = 0;

    assign rx = loop ? tx : rx_drv;

    uart_fifo #(.DATA_BITS(8), .FIFO_DEPTH(DEPTH), .DEFAULT_BAUD(433)) dut (
        .clk(clk), .rst_n(rst_n), .we(we), .re(re), .reg_num(reg_num), .wd(wd),
        .rd(rd), .rx(rx), .tx(tx), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] r, input logic [31:0] d);
        @(negedge clk);
        we = 1'b1; reg_num = r; wd = d;
        @(posedge clk); #1;
        we = 1'b0;
    endtask

    task automatic rdreg(input logic [2:0] r, output logic [31:0] d);
        @(negedge clk);
        re = 1'b1; reg_num = r;
        @(posedge clk); #1;
        re = 1'b0;
        d = rd;
    endtask

    // Waits (bounded) for the start bit, then samples each 4-clock bit mid-period.
    task automatic tx_frame(input string tag, input logic [31:0] exp, input int n, input bit busy_chk);
        logic [31:0] s;
        for (int i = 0; i < 20 && tx !== 1'b0; i++) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            repeat ((i == 0) ? 1 : 4) @(negedge clk);
            chk($sformatf("%s_bit%0d", tag, i), 32'(tx), 32'(exp[i]));
        end
        if (busy_chk) begin
            rdreg(3'd1, s);
            chk({tag, "_busy_last_stop"}, s, 32'h0000_0006);
        end
    endtask

    task automatic send_rx(input logic [7:0] d, input logic stop);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk) rx_drv = f[i];
            repeat (3) @(negedge clk);
        end
        @(negedge clk) rx_drv = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_rd", rd, 32'h0);
        chk("rst_tx", 32'(tx), 32'h1);
        chk("rst_irq", 32'(irq), 32'h0);
        rdreg(3'd1, v); chk("rst_stat", v, 32'h0000_0004);
        rdreg(3'd2, v); chk("rst_baud", v, 32'd433);
        rdreg(3'd0, v); chk("rst_ctrl", v, 32'h0);

        // 0xA5, 8N1, BAUD=3
        wr(3'd2, 32'd3);
        wr(3'd0, 32'h01);
        wr(3'd3, 32'hA5);
        tx_frame("a5", 32'b11_0100_1010, 10, 1'b1);
        rdreg(3'd1, v); chk("a5_busy_clk40", v, 32'h0000_0006);
        rdreg(3'd1, v); chk("a5_idle_clk41", v, 32'h0000_0004);

        // 0x07 with even then odd parity, two stop bits
        repeat (4) @(negedge clk);
        wr(3'd0, 32'h15);
        wr(3'd3, 32'h07);
        tx_frame("par_even", 32'b1110_0000_1110, 12, 1'b1);
        repeat (6) @(negedge clk);
        wr(3'd0, 32'h1D);
        wr(3'd3, 32'h07);
        tx_frame("par_odd", 32'b1100_0000_1110, 12, 1'b1);
        repeat (6) @(negedge clk);

        // Loopback, three back-to-back characters
        loop = 1'b1;
        wr(3'd0, 32'h03);
        wr(3'd3, 32'h11);
        wr(3'd3, 32'h22);
        wr(3'd3, 32'h33);
        tx_frame("loop", 32'({1'b1, 8'h33, 1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 8'h11, 1'b0}), 30, 1'b0);
        repeat (20) @(negedge clk);
        rdreg(3'd1, v); chk("loop_stat", v, 32'h0003_000C);
        rdreg(3'd4, v); chk("loop_rdr0", v, 32'h11);
        rdreg(3'd4, v); chk("loop_rdr1", v, 32'h22);
        rdreg(3'd4, v); chk("loop_rdr2", v, 32'h33);
        rdreg(3'd4, v); chk("loop_rdr_empty", v, 32'h0);
        loop = 1'b0;

        // RX overflow: DEPTH+1 frames, no reads
        for (int i = 0; i <= DEPTH; i++) send_rx(8'(8'h40 + i), 1'b1);
        rdreg(3'd1, v); chk("ovr_stat", v, 32'h0010_003C);
        wr(3'd1, 32'h20);
        rdreg(3'd1, v); chk("ovr_w1c", v, 32'h0010_001C);
        for (int i = 0; i < DEPTH; i++) begin
            rdreg(3'd4, v);
            chk($sformatf("ovr_rdr%0d", i), v, 32'h40 + 32'(i));
        end
        rdreg(3'd4, v); chk("ovr_rdr_empty", v, 32'h0);

        // Framing error: byte still stored
        send_rx(8'h5A, 1'b0);
        rdreg(3'd1, v); chk("frm_stat", v, 32'h0001_004C);
        rdreg(3'd4, v); chk("frm_rdr", v, 32'h5A);
        wr(3'd1, 32'h1E0);
        rdreg(3'd1, v); chk("frm_w1c", v, 32'h0000_0004);

        // One-clock low glitch on idle line
        @(negedge clk) rx_drv = 1'b0;
        @(negedge clk) rx_drv = 1'b1;
        repeat (12) @(negedge clk);
        rdreg(3'd1, v); chk("glitch_stat", v, 32'h0000_0004);

        // Interrupt sources
        wr(3'd0, 32'h22);
        repeat (2) @(negedge clk);
        chk("irq_rx_empty", 32'(irq), 32'h0);
        send_rx(8'h3C, 1'b1);
        repeat (2) @(negedge clk);
        chk("irq_rx_ne", 32'(irq), 32'h1);
        wr(3'd0, 32'h00);
        repeat (2) @(negedge clk);
        chk("irq_off", 32'(irq), 32'h0);
        wr(3'd0, 32'h40);
        repeat (2) @(negedge clk);
        chk("irq_tx_empty", 32'(irq), 32'h1);

        // TX overflow with ERRIE only, TX disabled
        wr(3'd0, 32'h80);
        repeat (2) @(negedge clk);
        chk("irq_err_none", 32'(irq), 32'h0);
        for (int i = 0; i <= DEPTH; i++) wr(3'd3, 32'(i));
        rdreg(3'd1, v); chk("txovf_stat", v, 32'h1001_0109);
        repeat (2) @(negedge clk);
        chk("irq_err", 32'(irq), 32'h1);

        // Reset in the middle of a start bit
        wr(3'd0, 32'h01);
        repeat (2) @(negedge clk);
        chk("pre_rst_tx_low", 32'(tx), 32'h0);
        rst_n = 1'b0;
        #1;
        chk("midrst_tx", 32'(tx), 32'h1);
        chk("midrst_irq", 32'(irq), 32'h0);
        chk("midrst_rd", rd, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        rdreg(3'd1, v); chk("post_rst_stat", v, 32'h0000_0004);
        rdreg(3'd2, v); chk("post_rst_baud", v, 32'd433);
        rdreg(3'd0, v); chk("post_rst_ctrl", v, 32'h0);
        rdreg(3'd4, v); chk("post_rst_rdr", v, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
